mem_bus_ctrl: RTL

Single-master memory bus controller between the CPU load/store port and the memory targets (flash, BRAM, SRAM, peripherals). It registers each CPU request and presents the registered address to the external address decoder. It then strobes the selected target, waits for that target's acknowledge or a timeout, and returns read data or an error to the CPU. The address decoder's combinational select/error outputs are inputs to this block.

---
 rtl/mem_bus_pkg.sv | 51 +++++
 rtl/mem_bus_timeout.sv | 27 ++
 rtl/mem_bus_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-side memory bus controller.
package mem_bus_pkg;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int NUM_TGT   = 4;
  localparam int TGT_IDX_W = 2;

  // Target indices, also the bit positions in tgt_stb / tgt_ack
  localparam int TGT_FLASH  = 0;
  localparam int TGT_BRAM   = 1;
  localparam int TGT_SRAM   = 2;
  localparam int TGT_PERIPH = 3;

  // Region bases as seen by the external decoder
  localparam logic [ADDR_W-1:0] FLASH_BASE  = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] BRAM_BASE   = 32'h0001_0000;
  localparam logic [ADDR_W-1:0] SRAM_BASE   = 32'h0002_0000;
  localparam logic [ADDR_W-1:0] PERIPH_BASE = 32'h0003_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // Captured CPU request
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } bus_req_t;

  // True when exactly one select is set
  function automatic logic is_one_hot(input logic [NUM_TGT-1:0] sel);
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

  // Index of the highest set select (only used once one-hotness is known)
  function automatic logic [TGT_IDX_W-1:0] sel_to_idx(input logic [NUM_TGT-1:0] sel);
    logic [TGT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_TGT; i++)
      if (sel[i]) idx = i[TGT_IDX_W-1:0];
    return idx;
  endfunction

endpackage

// File: rtl/mem_bus_timeout.sv
// Access watchdog: counts cycles while enabled, flags the last allowed cycle.
module mem_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Cycle counter; the owner leaves its state before the count could wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (en)   cnt_q <= cnt_q + CNT_W'(1);
  end

  // Fires in the cycle that holds count TIMEOUT_CYCLES-1
  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-master bus controller: registers a CPU request, checks the external
// decode, strobes one target and returns its data, an error or a timeout.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter bit FLASH_WRITABLE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_write,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [BE_W-1:0]    req_be,
  output logic               resp_valid,
  output logic [DATA_W-1:0]  resp_rdata,
  output logic               resp_error,
  output logic [ADDR_W-1:0]  dec_addr,
  input  logic               dec_flash_sel,
  input  logic               dec_bram_sel,
  input  logic               dec_sram_sel,
  input  logic               dec_periph_sel,
  input  logic               dec_error,
  output logic [ADDR_W-1:0]  tgt_addr,
  output logic               tgt_write,
  output logic [DATA_W-1:0]  tgt_wdata,
  output logic [BE_W-1:0]    tgt_be,
  output logic [NUM_TGT-1:0] tgt_stb,
  input  logic [NUM_TGT-1:0] tgt_ack,
  input  logic [DATA_W-1:0]  tgt_rdata_flash,
  input  logic [DATA_W-1:0]  tgt_rdata_bram,
  input  logic [DATA_W-1:0]  tgt_rdata_sram,
  input  logic [DATA_W-1:0]  tgt_rdata_periph
);

  state_e                           state_q, state_d;
  bus_req_t                         req_q;
  logic [TGT_IDX_W-1:0]             idx_q;
  logic [NUM_TGT-1:0]               stb_q;
  logic [DATA_W-1:0]                rdata_q;
  logic                             error_q;
  logic [NUM_TGT-1:0]               dec_sel;
  logic [NUM_TGT-1:0][DATA_W-1:0]   rdata_all;
  logic                             dec_bad;
  logic                             acked;
  logic                             expired;
  logic                             tmo_en;
  logic                             tmo_clr;

  assign dec_sel   = {dec_periph_sel, dec_sram_sel, dec_bram_sel, dec_flash_sel};
  assign rdata_all = {tgt_rdata_periph, tgt_rdata_sram, tgt_rdata_bram, tgt_rdata_flash};

  // Any reason to answer with an error instead of touching a target
  assign dec_bad = dec_error
                || (req_q.addr[1:0] != 2'b00)
                || (req_q.be == '0)
                || !is_one_hot(dec_sel)
                || (dec_sel[TGT_FLASH] && req_q.write && !FLASH_WRITABLE);

  // Only the strobed target's ack counts; others are ignored
  assign acked = tgt_ack[idx_q];

  mem_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshake outputs and watchdog control
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    tmo_en     = 1'b0;
    tmo_clr    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = dec_bad ? ST_RESP : ST_ACCESS;
      ST_ACCESS: begin
        tmo_en  = 1'b1;
        tmo_clr = 1'b0;
        if (acked || expired) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture; these registers also feed the decoder and target bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             req_q <= '0;
    else if (state_q == ST_IDLE && req_valid)
      req_q <= '{addr: req_addr, write: req_write, wdata: req_wdata, be: req_be};
  end

  // Target select and strobe, held for the whole access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      stb_q <= '0;
    end else if (state_q == ST_DECODE && !dec_bad) begin
      idx_q <= sel_to_idx(dec_sel);
      stb_q <= dec_sel;
    end else if (state_q == ST_ACCESS && (acked || expired)) begin
      stb_q <= '0;
    end
  end

  // Response data/error; held until the next response is formed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end else if (state_q == ST_DECODE && dec_bad) begin
      rdata_q <= '0;
      error_q <= 1'b1;
    end else if (state_q == ST_ACCESS && acked) begin
      rdata_q <= req_q.write ? '0 : rdata_all[idx_q];
      error_q <= 1'b0;
    end else if (state_q == ST_ACCESS && expired) begin
      rdata_q <= '0;
      error_q <= 1'b1;
    end
  end

  assign dec_addr   = req_q.addr;
  assign tgt_addr   = req_q.addr;
  assign tgt_write  = req_q.write;
  assign tgt_wdata  = req_q.wdata;
  assign tgt_be     = req_q.be;
  assign tgt_stb    = stb_q;
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule
